// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and frame constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-stage single-bit synchronizer with selectable reset value
module uart_sync #(
  parameter int STAGES = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= {STAGES{RESET_VAL}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receive stage, oversampled on sck_rising_edge
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int SAMPLE_POINT = 7,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sck_rising_edge,
  input  logic                 sin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_error,
  output logic                 receiver_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [SYNC_STAGES-1:0] warm;
  logic sin_s, armed, sample, wrap;
  uart_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(sin), .q(sin_s)
  );
  assign sample = sck_rising_edge && tick_cnt == TW'(SAMPLE_POINT);
  assign wrap   = sck_rising_edge && tick_cnt == TW'(OVERSAMPLE - 1);
  // warm masks the synchronizer's preset ones so a line held low across reset never arms
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      warm          <= '0;
      armed         <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_error      <= 1'b0;
      receiver_busy <= 1'b0;
    end else begin
      warm          <= {warm[SYNC_STAGES-2:0], 1'b1};
      rx_data_valid <= 1'b0;
      if (sck_rising_edge) tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
      if (!en) begin
        state         <= IDLE;
        receiver_busy <= 1'b0;
        armed         <= 1'b0;
      end else begin
        if (sin_s && warm[SYNC_STAGES-1]) armed <= 1'b1;
        case (state)
          IDLE: if (armed && !sin_s) begin
            state         <= START;
            tick_cnt      <= '0;
            receiver_busy <= 1'b1;
          end
          START: if (sample && sin_s) begin
            state         <= IDLE;
            receiver_busy <= 1'b0;
          end else if (wrap) begin
            state   <= DATA;
            bit_idx <= '0;
          end
          DATA: begin
            if (sample) shreg[bit_idx] <= sin_s;
            if (wrap) begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BW'(DATA_BITS - 1)) state <= STOP;
            end
          end
          STOP: if (sample) begin
            state         <= IDLE;
            rx_data       <= shreg;
            rx_error      <= !sin_s;
            rx_data_valid <= 1'b1;
            receiver_busy <= 1'b0;
            if (!sin_s) armed <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at 4 clk/strobe, 64 clk/bit
module tb_uart_receiver;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sin = 1'b1;
  logic [1:0] div = 2'd0;
  logic sck;
  logic [7:0] rx_data;
  logic rx_data_valid, rx_error, receiver_busy;
  int checks = 0, passed = 0;
  int vcnt = 0, wide = 0, busy_seen = 0, clk_cnt = 0, valid_at = 0;
  logic [7:0] vdata = 8'h00;
  logic verr = 1'b0, vprev = 1'b0;

  uart_receiver dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sck_rising_edge(sck), .sin(sin),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_error(rx_error),
    .receiver_busy(receiver_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 1'b1;
  assign sck = div == 2'd3;

  always @(negedge clk) begin
    clk_cnt++;
    if (rx_data_valid) begin
      vcnt++;
      vdata = rx_data;
      verr = rx_error;
      valid_at = clk_cnt;
    end
    if (rx_data_valid && vprev) wide++;
    if (receiver_busy) busy_seen++;
    vprev = rx_data_valid;
  end

  task automatic send_bit(input logic b);
    sin = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data); else passed++;
    checks++; if (rx_data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx_data_valid); else passed++;
    checks++; if (rx_error !== 1'b0) $display("FAIL reset_error: got %b expected 0", rx_error); else passed++;
    checks++; if (receiver_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", receiver_busy); else passed++;
    rst_n = 1'b1;
    en = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_good_byte;
    int v0, t0, lat;
    v0 = vcnt;
    t0 = clk_cnt;
    send_frame(8'hA5, 1'b1);
    repeat (16) @(negedge clk);
    lat = valid_at - t0;
    checks++; if (vcnt - v0 !== 1) $display("FAIL good_count: got %0d expected 1", vcnt - v0); else passed++;
    checks++; if (vdata !== 8'hA5) $display("FAIL good_data: got %h expected a5", vdata); else passed++;
    checks++; if (verr !== 1'b0) $display("FAIL good_error: got %b expected 0", verr); else passed++;
    checks++; if (receiver_busy !== 1'b0) $display("FAIL good_busy: got %b expected 0", receiver_busy); else passed++;
    checks++; if (lat < 603 || lat > 616) $display("FAIL good_latency: got %0d clks expected 603..616", lat); else passed++;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = vcnt;
    send_frame(8'h00, 1'b1);
    checks++; if (vdata !== 8'h00) $display("FAIL b2b_data0: got %h expected 00", vdata); else passed++;
    send_frame(8'hFF, 1'b1);
    checks++; if (vdata !== 8'hFF) $display("FAIL b2b_data1: got %h expected ff", vdata); else passed++;
    send_frame(8'h3C, 1'b1);
    checks++; if (vdata !== 8'h3C) $display("FAIL b2b_data2: got %h expected 3c", vdata); else passed++;
    repeat (16) @(negedge clk);
    checks++; if (vcnt - v0 !== 3) $display("FAIL b2b_count: got %0d expected 3", vcnt - v0); else passed++;
    checks++; if (verr !== 1'b0) $display("FAIL b2b_error: got %b expected 0", verr); else passed++;
  endtask

  task automatic test_framing;
    int v0;
    v0 = vcnt;
    send_frame(8'h5A, 1'b0);
    checks++; if (vcnt - v0 !== 1) $display("FAIL frm_count: got %0d expected 1", vcnt - v0); else passed++;
    checks++; if (vdata !== 8'h5A) $display("FAIL frm_data: got %h expected 5a", vdata); else passed++;
    checks++; if (verr !== 1'b1) $display("FAIL frm_error: got %b expected 1", verr); else passed++;
    sin = 1'b0;
    repeat (640) @(negedge clk);
    checks++; if (vcnt - v0 !== 1) $display("FAIL frm_break_count: got %0d expected 1", vcnt - v0); else passed++;
    checks++; if (receiver_busy !== 1'b0) $display("FAIL frm_break_busy: got %b expected 0", receiver_busy); else passed++;
    sin = 1'b1;
    repeat (128) @(negedge clk);
    send_frame(8'h11, 1'b1);
    repeat (16) @(negedge clk);
    checks++; if (vdata !== 8'h11) $display("FAIL frm_next_data: got %h expected 11", vdata); else passed++;
    checks++; if (rx_error !== 1'b0) $display("FAIL frm_next_error: got %b expected 0", rx_error); else passed++;
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcnt;
    busy_seen = 0;
    sin = 1'b0;
    repeat (16) @(negedge clk);
    sin = 1'b1;
    repeat (128) @(negedge clk);
    checks++; if (busy_seen == 0) $display("FAIL glitch_busy_pulse: got 0 busy clks expected >0"); else passed++;
    checks++; if (vcnt - v0 !== 0) $display("FAIL glitch_count: got %0d expected 0", vcnt - v0); else passed++;
    checks++; if (rx_data !== 8'h11) $display("FAIL glitch_data: got %h expected 11", rx_data); else passed++;
    checks++; if (receiver_busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", receiver_busy); else passed++;
  endtask

  task automatic test_abort;
    int v0;
    logic [9:0] f;
    v0 = vcnt;
    f = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 10; i++) begin
      sin = f[i];
      if (i == 3) begin
        repeat (32) @(negedge clk);
        checks++; if (receiver_busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", receiver_busy); else passed++;
        en = 1'b0;
        @(negedge clk);
        checks++; if (receiver_busy !== 1'b0) $display("FAIL abort_busy_drop: got %b expected 0", receiver_busy); else passed++;
        repeat (31) @(negedge clk);
      end else if (i == 5) begin
        repeat (32) @(negedge clk);
        en = 1'b1;
        repeat (32) @(negedge clk);
      end else begin
        repeat (64) @(negedge clk);
      end
    end
    checks++; if (vcnt - v0 !== 0) $display("FAIL abort_count: got %0d expected 0", vcnt - v0); else passed++;
    checks++; if (rx_data !== 8'h11) $display("FAIL abort_held_data: got %h expected 11", rx_data); else passed++;
    send_frame(8'h7E, 1'b1);
    checks++; if (vcnt - v0 !== 1) $display("FAIL abort_next_count: got %0d expected 1", vcnt - v0); else passed++;
    checks++; if (vdata !== 8'h7E) $display("FAIL abort_next_data: got %h expected 7e", vdata); else passed++;
  endtask

  task automatic test_mid_reset;
    int v0;
    logic [9:0] f;
    v0 = vcnt;
    f = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 10; i++) begin
      sin = f[i];
      if (i == 5) begin
        repeat (32) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) $display("FAIL mrst_data: got %h expected 00", rx_data); else passed++;
        checks++; if (rx_data_valid !== 1'b0) $display("FAIL mrst_valid: got %b expected 0", rx_data_valid); else passed++;
        checks++; if (rx_error !== 1'b0) $display("FAIL mrst_error: got %b expected 0", rx_error); else passed++;
        checks++; if (receiver_busy !== 1'b0) $display("FAIL mrst_busy: got %b expected 0", receiver_busy); else passed++;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (28) @(negedge clk);
      end else begin
        repeat (64) @(negedge clk);
      end
    end
    checks++; if (vcnt - v0 !== 0) $display("FAIL mrst_count: got %0d expected 0", vcnt - v0); else passed++;
    send_frame(8'h81, 1'b1);
    repeat (16) @(negedge clk);
    checks++; if (vcnt - v0 !== 1) $display("FAIL mrst_next_count: got %0d expected 1", vcnt - v0); else passed++;
    checks++; if (vdata !== 8'h81) $display("FAIL mrst_next_data: got %h expected 81", vdata); else passed++;
    checks++; if (verr !== 1'b0) $display("FAIL mrst_next_error: got %b expected 0", verr); else passed++;
  endtask

  task automatic test_valid_width;
    checks++; if (wide !== 0) $display("FAIL valid_width: got %0d multi-clk pulses expected 0", wide); else passed++;
  endtask

  initial begin
    test_reset;
    test_good_byte;
    test_back_to_back;
    test_framing;
    test_glitch;
    test_abort;
    test_mid_reset;
    test_valid_width;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
